seven_scan_animator: RTL and testbench
======================================

// Module: seven_scan_animator
// PURPOSE
//  Multiplexed driver for a DIGITS-digit seven-segment display. Time-slices
//  the anodes and drives shared cathodes with either hex glyphs or a 9-frame
//  spinner animation. The animation frame advances at a programmable sweep
//  rate, with an optional per-digit phase offset.
//  Sits between the status/debug logic and the board display pins.
// PARAMETERS
//  DIGITS       8       number of digits / anodes (>=2)
//  SLOT_CYCLES  100000  clk cycles per digit slot (>=4)
//  BLANK_CYCLES 16      cycles at slot start with all anodes off (< SLOT_CYCLES)
//  FRAME_SWEEPS 25      full digit sweeps per animation frame (>=1)
//  PHASE        1       animation frame offset per digit index (0..8)
//  ACTIVE_LOW   1       1: an/ca pins active-low; 0: active-high
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous active-low reset
//  en          in   1          1: scan runs; 0: counters hold, display blank
//  mode        in   2          00 blank, 01 hex, 10 spinner, 11 = blank
//  hex_value   in   4*DIGITS   nibble i shown on digit i (mode 01)
//  dp          in   DIGITS     decimal point for digit i (mode 01 only)
//  an          out  DIGITS     anode enables, one-hot when lit
//  ca          out  8          cathodes: [7]=dp, [6:0]=g..a
//  frame_tick  out  1          1-cycle pulse when animation frame advances
// BEHAVIOUR
//  - Internal segment polarity is active-high (1 = segment lit). Pins are
//    inverted when ACTIVE_LOW=1. All outputs are registered.
//  - Reset (async assert, sync release): slot_cnt=0, digit=0, sweep=0,
//    frame=0, frame_tick=0. an and ca are all inactive (all-1 when ACTIVE_LOW).
//  - slot_cnt counts 0..SLOT_CYCLES-1. At terminal count it wraps to 0 and
//    digit advances; digit wraps DIGITS-1 -> 0.
//  - On each digit wrap to 0, sweep advances; sweep wraps FRAME_SWEEPS-1 -> 0.
//  - On a sweep wrap, frame advances 0..8 and wraps 8 -> 0. frame_tick=1 for
//    exactly that cycle. Frame and sweep advance in every mode while en=1.
//  - mode, hex_value and dp are sampled once per slot, at slot_cnt==0, into
//    slot registers. Mid-slot input changes appear at the next slot (no glitch).
//  - Registered outputs, 1-cycle latency from counter state:
//      slot_cnt < BLANK_CYCLES   -> an all off, ca all off
//      otherwise                 -> an[digit] on (others off); ca = glyph
//  - Glyph selection:
//      mode 01 -> hex font, ca[7]=dp[digit]
//      mode 10 -> spinner table at index (frame + digit*PHASE) mod 9, dp off
//      00/11   -> ca off; an stays off for the whole slot
//  - Hex font (hex, [6:0]), digits 0-F:
//      3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
//  - Spinner table (8-bit incl. [7]), indices 0-8:
//      21 01 03 30 40 06 18 08 0C
//  - Modulo arithmetic is computed without a divider: digit*PHASE reduced
//    mod 9 by an incrementing accumulator that resets with digit.
//  - en=0: all counters hold; an/ca go inactive next cycle; frame_tick=0.
//    On en re-assert, counting resumes from the held state.
//  - rst_n assert mid-slot: outputs go inactive immediately (asynchronous).
// TESTING
//  1 Reset: rst_n=0 mid-run -> same-cycle an=8'hFF, ca=8'hFF, frame_tick=0;
//    after release, first lit anode is an[0] at cycle BLANK_CYCLES+1.
//  2 Hex scan (SLOT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=0):
//    hex_value=32'h76543210, dp=8'h01, mode=01 -> digit0 ca=8'hBF,
//    digit1 ca=8'h06; an one-hot walks 01,02..80, then wraps to 01.
//  3 Spinner (FRAME_SWEEPS=1, PHASE=1): frame=0 -> digit0 ca=21, digit1 ca=01,
//    digit8-mod-9 path exercised. frame_tick at each sweep wrap; frame 8 -> 0.
//  4 Mid-slot change: switch mode 01->10 at slot_cnt=5 -> current slot glyph
//    unchanged, next slot shows spinner.
//  5 en low for 50 cycles mid-slot -> an/ca inactive, counters frozen;
//    resume completes the slot with exactly the remaining cycles.
//  6 mode=11 -> an stays inactive for a full sweep; frame_tick still pulses.

Source files
------------

// File: rtl/seven_scan_animator.sv
// Multiplexed seven-segment driver: time-sliced anodes, shared cathodes showing
// hex glyphs or a 9-frame spinner whose frame advances every FRAME_SWEEPS sweeps.
module seven_scan_animator #(
    parameter int DIGITS       = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int FRAME_SWEEPS = 25,
    parameter int PHASE        = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   hex_value,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            ca,
    output logic                  frame_tick
);
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (FRAME_SWEEPS > 1) ? $clog2(FRAME_SWEEPS) : 1;

    localparam logic [SW-1:0] SLOT_LAST   = SW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0] BLANK_END   = SW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST  = DW'(DIGITS - 1);
    localparam logic [FW-1:0] SWEEP_LAST  = FW'(FRAME_SWEEPS - 1);
    localparam logic [3:0]    PHASE_STEP  = 4'(PHASE % 9);

    logic [SW-1:0]     slot_cnt_reg;
    logic [DW-1:0]     digit_reg;
    logic [FW-1:0]     sweep_reg;
    logic [3:0]        frame_reg;
    logic [3:0]        phase_acc_reg;
    logic              frame_tick_reg;
    logic [1:0]        mode_slot_reg;
    logic [3:0]        nib_slot_reg;
    logic              dp_slot_reg;
    logic [DIGITS-1:0] an_reg;
    logic [7:0]        ca_reg;

    logic              slot_start, slot_end, digit_end, sweep_end, frame_adv;
    logic [3:0]        phase_sum, phase_acc_next;
    logic [4:0]        spin_sum;
    logic [3:0]        spin_idx;
    logic [1:0]        mode_cur;
    logic [3:0]        nib_cur;
    logic              dp_cur;
    logic [DIGITS-1:0] onehot;
    logic [3:0]        nib_arr [DIGITS];
    logic [6:0]        hex_glyph;
    logic [7:0]        spin_glyph;
    logic [DIGITS-1:0] an_next;
    logic [7:0]        ca_next;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = hex_value[4*gi +: 4];
            assign onehot[gi]  = (digit_reg == DW'(gi));
        end
    endgenerate

    assign slot_start = (slot_cnt_reg == '0);
    assign slot_end   = (slot_cnt_reg == SLOT_LAST);
    assign digit_end  = (digit_reg == DIGIT_LAST);
    assign sweep_end  = (sweep_reg == SWEEP_LAST);
    assign frame_adv  = en & slot_end & digit_end & sweep_end;

    // digit*PHASE mod 9 tracked incrementally alongside the digit counter
    assign phase_sum      = phase_acc_reg + PHASE_STEP;
    assign phase_acc_next = (phase_sum >= 4'd9) ? phase_sum - 4'd9 : phase_sum;
    assign spin_sum       = {1'b0, frame_reg} + {1'b0, phase_acc_reg};
    assign spin_idx       = (spin_sum >= 5'd9) ? 4'(spin_sum - 5'd9) : spin_sum[3:0];

    // The slot's first cycle sees the live inputs; later cycles use the latched copy
    assign mode_cur = slot_start ? mode : mode_slot_reg;
    assign nib_cur  = slot_start ? nib_arr[digit_reg] : nib_slot_reg;
    assign dp_cur   = slot_start ? dp[digit_reg] : dp_slot_reg;

    always_comb begin
        hex_glyph = 7'h00;
        case (nib_cur)
            4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;  4'hF: hex_glyph = 7'h71;
            default: hex_glyph = 7'h00;
        endcase
    end

    always_comb begin
        spin_glyph = 8'h00;
        case (spin_idx)
            4'd0: spin_glyph = 8'h21;  4'd1: spin_glyph = 8'h01;
            4'd2: spin_glyph = 8'h03;  4'd3: spin_glyph = 8'h30;
            4'd4: spin_glyph = 8'h40;  4'd5: spin_glyph = 8'h06;
            4'd6: spin_glyph = 8'h18;  4'd7: spin_glyph = 8'h08;
            4'd8: spin_glyph = 8'h0C;
            default: spin_glyph = 8'h00;
        endcase
    end

    always_comb begin
        an_next = '0;
        ca_next = 8'h00;
        if (en && (slot_cnt_reg >= BLANK_END)) begin
            if (mode_cur == 2'b01) begin
                an_next = onehot;
                ca_next = {dp_cur, hex_glyph};
            end else if (mode_cur == 2'b10) begin
                an_next = onehot;
                ca_next = {1'b0, spin_glyph[6:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg   <= '0;
            digit_reg      <= '0;
            sweep_reg      <= '0;
            frame_reg      <= '0;
            phase_acc_reg  <= '0;
            frame_tick_reg <= 1'b0;
            mode_slot_reg  <= 2'b00;
            nib_slot_reg   <= 4'h0;
            dp_slot_reg    <= 1'b0;
            an_reg         <= '0;
            ca_reg         <= 8'h00;
        end else begin
            frame_tick_reg <= frame_adv;
            an_reg         <= an_next;
            ca_reg         <= ca_next;
            if (en) begin
                if (slot_start) begin
                    mode_slot_reg <= mode;
                    nib_slot_reg  <= nib_arr[digit_reg];
                    dp_slot_reg   <= dp[digit_reg];
                end
                slot_cnt_reg <= slot_end ? '0 : slot_cnt_reg + 1'b1;
                if (slot_end) begin
                    digit_reg     <= digit_end ? '0 : digit_reg + 1'b1;
                    phase_acc_reg <= digit_end ? 4'd0 : phase_acc_next;
                    if (digit_end) begin
                        sweep_reg <= sweep_end ? '0 : sweep_reg + 1'b1;
                        if (sweep_end)
                            frame_reg <= (frame_reg == 4'd8) ? 4'd0 : frame_reg + 4'd1;
                    end
                end
            end
        end
    end

    assign an         = (ACTIVE_LOW != 0) ? ~an_reg : an_reg;
    assign ca         = (ACTIVE_LOW != 0) ? ~ca_reg : ca_reg;
    assign frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_seven_scan_animator.sv
// Directed bench for seven_scan_animator: 8 digits, 8-cycle slots, 2 blank cycles,
// one sweep per frame; an active-high and an active-low instance share the stimulus.
module tb_seven_scan_animator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [1:0]  mode = 2'b01;
    logic [31:0] hex_value = 32'h76543210;
    logic [7:0]  dp = 8'h01;
    logic [7:0]  an, an_al, ca, ca_al;
    logic        frame_tick, frame_tick_al;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    logic [7:0] font [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0] spin [9]  = '{8'h21, 8'h01, 8'h03, 8'h30, 8'h40, 8'h06, 8'h18, 8'h08, 8'h0C};

    always #5 clk = ~clk;

    seven_scan_animator #(.DIGITS(8), .SLOT_CYCLES(8), .BLANK_CYCLES(2), .FRAME_SWEEPS(1),
                          .PHASE(1), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .hex_value(hex_value), .dp(dp),
        .an(an), .ca(ca), .frame_tick(frame_tick));

    seven_scan_animator #(.DIGITS(8), .SLOT_CYCLES(8), .BLANK_CYCLES(2), .FRAME_SWEEPS(1),
                          .PHASE(1), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .hex_value(hex_value), .dp(dp),
        .an(an_al), .ca(ca_al), .frame_tick(frame_tick_al));

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    // Counters are zero after this; edge 1 is the first edge processing state 0
    task automatic do_reset(input logic [1:0] m);
        mode = m;
        en = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        do_reset(2'b01);
        run_to(20);
        n_cmp++;
        if (an !== 8'h04) begin n_bad++; $display("FAIL pre_reset_an got=%h exp=%h", an, 8'h04); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (an_al !== 8'hFF || ca_al !== 8'hFF || frame_tick_al !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_al got an=%h ca=%h ft=%b exp an=FF ca=FF ft=0", an_al, ca_al, frame_tick_al);
        end
        n_cmp++;
        if (an !== 8'h00 || ca !== 8'h00) begin
            n_bad++; $display("FAIL async_reset got an=%h ca=%h exp an=00 ca=00", an, ca);
        end
        tick();
        rst_n = 1'b1;
        edge_n = 0;
        run_to(2);
        n_cmp++;
        if (an !== 8'h00) begin n_bad++; $display("FAIL reset_blank got=%h exp=00", an); end
        run_to(3);
        n_cmp++;
        if (an !== 8'h01 || ca !== 8'hBF) begin
            n_bad++; $display("FAIL first_lit got an=%h ca=%h exp an=01 ca=BF", an, ca);
        end
        $display("reset: first lit anode at edge %0d an=%h ca=%h", edge_n, an, ca);
    endtask

    task automatic test_hex_scan();
        logic [7:0] exp_an, exp_ca;
        do_reset(2'b01);
        for (int d = 0; d <= 8; d++) begin
            run_to(d*8 + 2);
            n_cmp++;
            if (an !== 8'h00 || ca !== 8'h00) begin
                n_bad++; $display("FAIL hex_blank d=%0d got an=%h ca=%h exp 00/00", d, an, ca);
            end
            run_to(d*8 + 3);
            exp_an = 8'h01 << (d % 8);
            exp_ca = font[d % 8] | ((d % 8 == 0) ? 8'h80 : 8'h00);
            n_cmp++;
            if (an !== exp_an || ca !== exp_ca) begin
                n_bad++; $display("FAIL hex_lit d=%0d got an=%h ca=%h exp an=%h ca=%h", d, an, ca, exp_an, exp_ca);
            end
            n_cmp++;
            if (an_al !== ~exp_an || ca_al !== ~exp_ca) begin
                n_bad++; $display("FAIL hex_lit_al d=%0d got an=%h ca=%h exp an=%h ca=%h", d, an_al, ca_al, ~exp_an, ~exp_ca);
            end
            $display("hex: digit %0d an=%h ca=%h", d % 8, an, ca);
        end
    endtask

    task automatic test_spinner();
        logic [7:0] exp_ca;
        do_reset(2'b10);
        for (int f = 0; f <= 9; f++) begin
            for (int d = 0; d < 8; d++) begin
                run_to(f*64 + d*8 + 3);
                exp_ca = spin[((f % 9) + d) % 9] & 8'h7F;
                n_cmp++;
                if (an !== (8'h01 << d) || ca !== exp_ca) begin
                    n_bad++; $display("FAIL spin f=%0d d=%0d got an=%h ca=%h exp an=%h ca=%h", f, d, an, ca, 8'h01 << d, exp_ca);
                end
            end
            if (f < 9) begin
                run_to(f*64 + 63);
                n_cmp++;
                if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL tick_early f=%0d got=%b exp=0", f, frame_tick); end
                run_to(f*64 + 64);
                n_cmp++;
                if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL tick_pulse f=%0d got=%b exp=1", f, frame_tick); end
                run_to(f*64 + 65);
                n_cmp++;
                if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL tick_width f=%0d got=%b exp=0", f, frame_tick); end
            end
            $display("spin: sweep %0d checked", f);
        end
    endtask

    task automatic test_midslot();
        do_reset(2'b01);
        run_to(5);
        mode = 2'b10;
        for (int e = 6; e <= 8; e++) begin
            run_to(e);
            n_cmp++;
            if (an !== 8'h01 || ca !== 8'hBF) begin
                n_bad++; $display("FAIL midslot_hold e=%0d got an=%h ca=%h exp an=01 ca=BF", e, an, ca);
            end
        end
        run_to(11);
        n_cmp++;
        if (an !== 8'h02 || ca !== 8'h01) begin
            n_bad++; $display("FAIL midslot_next got an=%h ca=%h exp an=02 ca=01", an, ca);
        end
        $display("midslot: next slot an=%h ca=%h", an, ca);
    endtask

    task automatic test_enable();
        do_reset(2'b01);
        run_to(4);
        en = 1'b0;
        run_to(5);
        n_cmp++;
        if (an !== 8'h00 || ca !== 8'h00) begin
            n_bad++; $display("FAIL en_off got an=%h ca=%h exp 00/00", an, ca);
        end
        run_to(54);
        n_cmp++;
        if (an !== 8'h00 || ca !== 8'h00 || frame_tick !== 1'b0) begin
            n_bad++; $display("FAIL en_hold got an=%h ca=%h ft=%b exp 00/00/0", an, ca, frame_tick);
        end
        en = 1'b1;
        run_to(55);
        n_cmp++;
        if (an !== 8'h01 || ca !== 8'hBF) begin
            n_bad++; $display("FAIL en_resume got an=%h ca=%h exp an=01 ca=BF", an, ca);
        end
        run_to(58);
        n_cmp++;
        if (an !== 8'h01) begin n_bad++; $display("FAIL en_slot_tail got=%h exp=01", an); end
        run_to(59);
        n_cmp++;
        if (an !== 8'h00) begin n_bad++; $display("FAIL en_slot_end got=%h exp=00", an); end
        run_to(61);
        n_cmp++;
        if (an !== 8'h02 || ca !== 8'h06) begin
            n_bad++; $display("FAIL en_next_digit got an=%h ca=%h exp an=02 ca=06", an, ca);
        end
        $display("enable: resumed, digit1 at edge %0d an=%h", edge_n, an);
    endtask

    task automatic test_mode11();
        int lit;
        lit = 0;
        do_reset(2'b11);
        for (int e = 1; e <= 64; e++) begin
            run_to(e);
            if (an !== 8'h00 || ca !== 8'h00) lit++;
        end
        n_cmp++;
        if (lit != 0) begin n_bad++; $display("FAIL mode11_dark got lit_cycles=%0d exp=0", lit); end
        n_cmp++;
        if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL mode11_tick got=%b exp=1", frame_tick); end
        $display("mode11: lit cycles=%0d frame_tick=%b", lit, frame_tick);
    endtask

    initial begin
        test_reset();
        test_hex_scan();
        test_spinner();
        test_midslot();
        test_enable();
        test_mode11();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
